// File: rtl/mux_pkg.sv
// Shared constants for the N-channel registered mux: mode encodings and a
// ceiling-log2 helper used to validate the select width at elaboration.
package mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int p = 1; p < value; p = p * 2) r++;
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotate-priority scan: the first requester after ptr wins,
// wrapping modulo NCH, with ptr itself examined last.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int NCH  = 4,
  parameter int SELW = 2
) (
  input  logic [NCH-1:0]  req,
  input  logic [SELW-1:0] ptr,
  output logic [SELW-1:0] gnt_idx,
  output logic            gnt_any
);

  // Walk from the farthest offset back to the nearest so the nearest requester is the final winner.
  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int k = NCH; k >= 1; k--) begin
      if (req[(int'(ptr) + k) % NCH]) begin
        gnt_any = 1'b1;
        gnt_idx = SELW'((int'(ptr) + k) % NCH);
      end
    end
  end

endmodule

// File: rtl/mux_rr_n.sv
// N-channel registered mux with fixed-select or round-robin grant and a one-entry
// valid/ready output register. Optional output parity port under MUX_PARITY_EN.
module mux_rr_n
  import mux_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NCH   = 4,
  parameter int SELW  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  output logic [WIDTH-1:0]     y_out,
  output logic                 y_valid,
  input  logic                 y_ready,
  output logic [SELW-1:0]      y_chan
`ifdef MUX_PARITY_EN
  ,output logic                y_par
`endif
);

  if (SELW != clog2(NCH)) begin : g_bad_selw
    $error("mux_rr_n: SELW must equal clog2(NCH)");
  end

  logic [WIDTH-1:0] y_out_q, y_out_d;
  logic             y_valid_q, y_valid_d;
  logic [SELW-1:0]  y_chan_q, y_chan_d;
  logic [SELW-1:0]  rr_ptr_q, rr_ptr_d;
  logic             y_par_q, y_par_d;

  logic [SELW-1:0]  rr_idx, gnt_idx;
  logic             rr_any, fix_any, gnt_any;
  logic             load, take;
  logic [WIDTH-1:0] sel_word;

  rr_arbiter #(.NCH(NCH), .SELW(SELW)) u_arb (
    .req     (in_valid),
    .ptr     (rr_ptr_q),
    .gnt_idx (rr_idx),
    .gnt_any (rr_any)
  );

  // Explicit compare loop keeps an out-of-range sel from ever granting.
  always_comb begin
    fix_any = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      if (int'(sel) == k && in_valid[k]) fix_any = 1'b1;
    end
  end

  assign gnt_idx = (mode == MODE_RR) ? rr_idx : sel;
  assign gnt_any = (mode == MODE_RR) ? rr_any : fix_any;
  assign load    = !y_valid_q || y_ready;
  assign take    = gnt_any && load && !rst;

  for (genvar gi = 0; gi < NCH; gi++) begin : g_ready
    assign in_ready[gi] = take && (int'(gnt_idx) == gi);
  end

  always_comb begin
    sel_word = '0;
    for (int k = 0; k < NCH; k++) begin
      if (int'(gnt_idx) == k) sel_word = in_data[k*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    y_out_d   = y_out_q;
    y_valid_d = y_valid_q;
    y_chan_d  = y_chan_q;
    y_par_d   = y_par_q;
    rr_ptr_d  = rr_ptr_q;
    if (take) begin
      y_out_d   = sel_word;
      y_valid_d = 1'b1;
      y_chan_d  = gnt_idx;
      y_par_d   = ^sel_word;
      rr_ptr_d  = gnt_idx;
    end else if (y_valid_q && y_ready) begin
      y_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y_out_q   <= '0;
      y_valid_q <= 1'b0;
      y_chan_q  <= '0;
      y_par_q   <= 1'b0;
      rr_ptr_q  <= SELW'(NCH - 1);
    end else begin
      y_out_q   <= y_out_d;
      y_valid_q <= y_valid_d;
      y_chan_q  <= y_chan_d;
      y_par_q   <= y_par_d;
      rr_ptr_q  <= rr_ptr_d;
    end
  end

  assign y_out   = y_out_q;
  assign y_valid = y_valid_q;
  assign y_chan  = y_chan_q;
`ifdef MUX_PARITY_EN
  assign y_par   = y_par_q;
`else
  logic unused_par;
  assign unused_par = y_par_q;
`endif

endmodule

// File: tb/tb_mux_rr_n.sv
// Self-checking bench for mux_rr_n: directed scenarios followed by randomized
// traffic, all compared against a transaction-level reference model.
module tb_mux_rr_n;

  localparam int WIDTH = 8;
  localparam int NCH   = 4;
  localparam int SELW  = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NCH*WIDTH-1:0] in_data;
  logic [NCH-1:0]       in_valid;
  logic [NCH-1:0]       in_ready;
  logic                 mode;
  logic [SELW-1:0]      sel;
  logic [WIDTH-1:0]     y_out;
  logic                 y_valid;
  logic                 y_ready;
  logic [SELW-1:0]      y_chan;
`ifdef MUX_PARITY_EN
  logic                 y_par;
`endif

  always #5 clk = ~clk;

  mux_rr_n #(.WIDTH(WIDTH), .NCH(NCH), .SELW(SELW)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .mode     (mode),
    .sel      (sel),
    .y_out    (y_out),
    .y_valid  (y_valid),
    .y_ready  (y_ready),
    .y_chan   (y_chan)
`ifdef MUX_PARITY_EN
    ,.y_par   (y_par)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state: the held output word and the last granted channel.
  bit         m_valid;
  int         m_out;
  int         m_chan;
  int         m_par;
  int         m_ptr;
  int         m_g;
  bit         m_take;
  logic [NCH-1:0] rdy_seen;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int chan_word(input logic [NCH*WIDTH-1:0] d, input int c);
    return int'(d >> (c * WIDTH)) & ((1 << WIDTH) - 1);
  endfunction

  // One clock: drive, check in_ready before the edge, advance the model, check outputs after.
  task automatic cycle(input logic r, input logic [NCH-1:0] v, input logic [NCH*WIDTH-1:0] d,
                       input logic md, input logic [SELW-1:0] s, input logic yr);
    logic [NCH-1:0] exp_rdy;
    bit can_load;
    int w;
    @(negedge clk);
    rst = r; in_valid = v; in_data = d; mode = md; sel = s; y_ready = yr;
    #1;
    can_load = !m_valid || yr;
    m_g = -1;
    if (!md) begin
      if (int'(s) < NCH && v[s]) m_g = int'(s);
    end else begin
      for (int k = 1; k <= NCH && m_g < 0; k++)
        if (v[(m_ptr + k) % NCH]) m_g = (m_ptr + k) % NCH;
    end
    m_take = !r && can_load && (m_g >= 0);
    exp_rdy = m_take ? NCH'(1 << m_g) : '0;
    rdy_seen = in_ready;
    check_eq("in_ready", 32'(in_ready), 32'(exp_rdy));
    @(posedge clk);
    if (r) begin
      m_valid = 0; m_out = 0; m_chan = 0; m_par = 0; m_ptr = NCH - 1;
    end else if (m_take) begin
      w = chan_word(d, m_g);
      m_valid = 1; m_out = w; m_chan = m_g; m_par = $countones(w) % 2; m_ptr = m_g;
    end else if (m_valid && yr) begin
      m_valid = 0;
    end
    #1;
    check_eq("y_valid", 32'(y_valid), 32'(m_valid));
    check_eq("y_out", 32'(y_out), 32'(m_out));
    check_eq("y_chan", 32'(y_chan), 32'(m_chan));
`ifdef MUX_PARITY_EN
    check_eq("y_par", 32'(y_par), 32'(m_par));
`endif
  endtask

  localparam logic [NCH*WIDTH-1:0] DATA_A = {8'h44, 8'h0A, 8'h22, 8'h11};

  initial begin
    int sparse_exp [4];
    sparse_exp = '{1, 3, 1, 3};
    rst = 1'b1; in_valid = '0; in_data = '0; mode = 1'b0; sel = '0; y_ready = 1'b0;
    m_valid = 0; m_out = 0; m_chan = 0; m_par = 0; m_ptr = NCH - 1;

    // Reset with every channel requesting
    repeat (2) cycle(1'b1, 4'hF, DATA_A, 1'b1, 2'd0, 1'b1);
    check_eq("rst_ready", 32'(rdy_seen), 32'h0);
    check_eq("rst_valid", 32'(y_valid), 32'h0);
    $display("reset: y_valid=%0d y_out=%0h y_chan=%0d", y_valid, y_out, y_chan);

    // Fixed select of channel 2
    cycle(1'b0, 4'hF, DATA_A, 1'b0, 2'd2, 1'b1);
    check_eq("fixed_ready", 32'(rdy_seen), 32'h4);
    check_eq("fixed_y", 32'(y_out), 32'h0A);
    check_eq("fixed_chan", 32'(y_chan), 32'd2);
    $display("fixed: in_ready=%b y_out=%0h y_chan=%0d", rdy_seen, y_out, y_chan);

    // Round-robin, all valid, from reset
    cycle(1'b1, 4'hF, DATA_A, 1'b1, 2'd0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, 4'hF, DATA_A, 1'b1, 2'd0, 1'b1);
      check_eq("rr_seq", 32'(y_chan), 32'(i % NCH));
      $display("rr: y_chan=%0d y_out=%0h", y_chan, y_out);
    end

    // Sparse round-robin
    cycle(1'b1, 4'hF, DATA_A, 1'b1, 2'd0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 4'b1010, DATA_A, 1'b1, 2'd0, 1'b1);
      check_eq("rr_sparse", 32'(y_chan), 32'(sparse_exp[i]));
      $display("sparse: y_chan=%0d", y_chan);
    end

    // Backpressure holding 0x55, then drain and reload in one cycle
    cycle(1'b0, 4'b0001, {24'h0, 8'h55}, 1'b0, 2'd0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 4'b0001, {24'h0, 8'h66}, 1'b0, 2'd0, 1'b0);
      check_eq("stall_y", 32'(y_out), 32'h55);
      check_eq("stall_ready", 32'(rdy_seen), 32'h0);
      $display("stall: y_out=%0h in_ready=%b", y_out, rdy_seen);
    end
    cycle(1'b0, 4'b0001, {24'h0, 8'h66}, 1'b0, 2'd0, 1'b1);
    check_eq("drain_load", 32'(y_out), 32'h66);
    check_eq("drain_valid", 32'(y_valid), 32'h1);
    $display("drain: y_out=%0h y_valid=%0d", y_out, y_valid);

    // Reset while stalled, then round-robin restarts at channel 0
    cycle(1'b0, 4'b0000, DATA_A, 1'b0, 2'd0, 1'b0);
    cycle(1'b1, 4'hF, DATA_A, 1'b1, 2'd0, 1'b0);
    check_eq("midrst_valid", 32'(y_valid), 32'h0);
    cycle(1'b0, 4'hF, DATA_A, 1'b1, 2'd0, 1'b1);
    check_eq("midrst_rr0", 32'(y_chan), 32'h0);
    $display("mid-reset: y_chan=%0d y_valid=%0d", y_chan, y_valid);

`ifdef MUX_PARITY_EN
    cycle(1'b0, 4'b0010, {16'h0, 8'h07, 8'h0}, 1'b0, 2'd1, 1'b1);
    check_eq("parity_07", 32'(y_par), 32'h1);
    $display("parity: y_out=%0h y_par=%0d", y_out, y_par);
`endif

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      cycle(($urandom_range(0, 49) == 0), NCH'($urandom), NCH*WIDTH'($urandom),
            1'($urandom), SELW'($urandom), ($urandom_range(0, 3) != 0));
      if (i % 250 == 0)
        $display("rand %0d: y_valid=%0d y_chan=%0d y_out=%0h", i, y_valid, y_chan, y_out);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
